// File: rtl/alu_result_stage.sv
// ALU result stage: computes a W-bit ALU op at accept time and holds the
// result plus flags in a 2-entry skid buffer (head drives the outputs, skid
// absorbs one extra entry so in_ready can be a registered signal).
module alu_result_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         ovf
);

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         ovf;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  entry_t head_q, skid_q;
  logic   in_ready_q, out_valid_q;
  entry_t new_d;
  logic   [W:0] sum_d;
  logic   accept, xfer;

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  // ALU: result and flags for the operation currently offered upstream
  always_comb begin
    sum_d     = '0;
    new_d     = '0;
    unique case (op)
      3'b000: new_d.res = a & b;
      3'b001: new_d.res = a | b;
      3'b010: new_d.res = a ^ b;
      3'b011: new_d.res = ~(a | b);
      3'b100: begin
        sum_d       = {1'b0, a} + {1'b0, b};
        new_d.res   = sum_d[W-1:0];
        new_d.carry = sum_d[W];
        new_d.ovf   = (a[W-1] == b[W-1]) && (sum_d[W-1] != a[W-1]);
      end
      3'b101: begin
        // carry set means no borrow, i.e. a >= b unsigned
        sum_d       = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        new_d.res   = sum_d[W-1:0];
        new_d.carry = sum_d[W];
        new_d.ovf   = (a[W-1] != b[W-1]) && (sum_d[W-1] != a[W-1]);
      end
      3'b110: new_d.res = a;
      default: new_d.res = ~a;
    endcase
    new_d.zero = (new_d.res == '0);
  end

  // Skid-buffer FSM; in_ready/out_valid are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q      <= new_d;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            head_q <= new_d;
          end else if (accept) begin
            skid_q     <= new_d;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (xfer) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (xfer) begin
            head_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = head_q.res;
  assign zero      = head_q.zero;
  assign carry     = head_q.carry;
  assign ovf       = head_q.ovf;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (W=8) with hand-computed expectations.
module tb_alu_result_stage;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, carry, ovf;

  int n_chk  = 0;
  int n_fail = 0;

  alu_result_stage #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock, then settle past the edge before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r,
                         input logic z, input logic c, input logic o);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".res"},   result,    r);
    chk({tag, ".zero"},  zero,      z);
    chk({tag, ".carry"}, carry,     c);
    chk({tag, ".ovf"},   ovf,       o);
  endtask

  // offer one op with out_ready=1; result is visible one cycle after accept
  task automatic issue(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb);
    in_valid  = 1'b1;
    op        = o;
    a         = xa;
    b         = xb;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  logic [7:0] bw_exp [6];
  logic [2:0] bw_op  [6];

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    bw_op  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    bw_exp = '{8'h88,  8'hEE,  8'h66,  8'h11,  8'hCC,  8'h33};

    // reset then idle
    #1; tick(); tick();
    rst = 1'b0;
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.ready", in_ready,  1'b1);
    chk("rst.res",   result,    8'h00);
    chk("rst.flags", {zero, carry, ovf}, 3'b000);
    tick();
    chk("idle.valid", out_valid, 1'b0);

    // ADD
    issue(3'b100, 8'h7F, 8'h01); chk_out("add7f", 8'h80, 1'b0, 1'b0, 1'b1);
    issue(3'b100, 8'hFF, 8'h01); chk_out("addff", 8'h00, 1'b1, 1'b1, 1'b0);
    // SUB
    issue(3'b101, 8'h05, 8'h05); chk_out("sub55", 8'h00, 1'b1, 1'b1, 1'b0);
    issue(3'b101, 8'h00, 8'h01); chk_out("sub01", 8'hFF, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 8'h80, 8'h01); chk_out("sub80", 8'h7F, 1'b0, 1'b1, 1'b1);
    // bitwise sweep
    for (int i = 0; i < 6; i++) begin
      issue(bw_op[i], 8'hCC, 8'hAA);
      chk_out($sformatf("bw%0d", i), bw_exp[i], 1'b0, 1'b0, 1'b0);
    end

    // drain: ONE + transfer, no accept -> EMPTY, outputs hold
    tick();
    chk("drain.valid", out_valid, 1'b0);
    chk("drain.hold",  result,    8'h33);
    chk("drain.ready", in_ready,  1'b1);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b100; a = 8'h01; b = 8'h01;
    tick();
    chk("bp1.ready", in_ready, 1'b1);
    chk("bp1.res",   result,   8'h02);
    a = 8'h02; b = 8'h02;
    tick();
    chk("bp2.ready", in_ready, 1'b0);
    chk("bp2.res",   result,   8'h02);
    a = 8'h03; b = 8'h03;
    tick();
    chk("bp3.ready", in_ready, 1'b0);
    chk("bp3.res",   result,   8'h02);
    chk("bp3.valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("bp4.res",   result,   8'h04);
    chk("bp4.ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp5.res",   result,   8'h06);
    chk("bp5.valid", out_valid, 1'b1);
    tick();
    chk("bp6.valid", out_valid, 1'b0);
    chk("bp6.hold",  result,    8'h06);

    // fill to FULL, then reset with in_valid/out_ready high
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b100; a = 8'h11; b = 8'h11;
    tick(); tick();
    chk("full.ready", in_ready, 1'b0);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rfull.valid", out_valid, 1'b0);
    chk("rfull.ready", in_ready,  1'b1);
    chk("rfull.res",   result,    8'h00);
    chk("rfull.flags", {zero, carry, ovf}, 3'b000);
    issue(3'b100, 8'h10, 8'h20); chk_out("post", 8'h30, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post.drain", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: W, 8, operand/result width in bits (W >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream offers an operation this cycle.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 op  input  3  operation select: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB (A-B), 110 PASS A, 111 NOT A.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 out_valid  output  1  result entry presented downstream.
REQ-010 out_ready  input  1  downstream accepts the presented entry.
REQ-011 result  output  W  registered result of the head entry.
REQ-012 zero  output  1  head entry result == 0.
REQ-013 carry  output  1  head entry carry: ADD carry-out; SUB 1 when A >= B unsigned (no borrow); 0 for all other ops.
REQ-014 ovf  output  1  head entry signed overflow for ADD/SUB; 0 for all other ops.

Function
REQ-015 Accept occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-016 Result and flags are computed combinationally from op/a/b at accept and stored with the entry; W-bit arithmetic wraps modulo 2^W.
REQ-017 ADD computed on W+1 bits: carry = bit W; ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
REQ-018 SUB computed as a + ~b + 1 on W+1 bits: carry = bit W; ovf = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]).
REQ-019 Storage is a 2-entry skid buffer: head register (drives outputs) and skid register; state EMPTY (0 entries), ONE (head full), FULL (head+skid full).
REQ-020 in_ready is a registered signal, 1 in EMPTY and ONE, 0 in FULL; it does not depend combinationally on out_ready.
REQ-021 out_valid = 1 in ONE and FULL, 0 in EMPTY.
REQ-022 EMPTY + accept -> ONE, entry loaded into head; latency accept-to-out_valid is 1 cycle.
REQ-023 ONE + accept + transfer -> ONE, head replaced by new entry (sustained 1 op/cycle).
REQ-024 ONE + accept, no transfer -> FULL, new entry into skid, head unchanged.
REQ-025 ONE + transfer, no accept -> EMPTY.
REQ-026 FULL + transfer -> ONE, skid moves to head; no accept possible in FULL.
REQ-027 FULL, no transfer -> FULL; head outputs held stable while out_valid && !out_ready.
REQ-028 Entries leave in exactly accept order; no entry is dropped or duplicated.
REQ-029 result/zero/carry/ovf are don't-care while out_valid = 0 but shall hold last head values (no X after reset).

Reset
REQ-030 rst sampled at rising edge forces state EMPTY: out_valid = 0, in_ready = 1, result = 0, zero = 0, carry = 0, ovf = 0, skid cleared.
REQ-031 rst asserted mid-operation (ONE or FULL) discards all entries regardless of in_valid/out_ready that cycle; no accept occurs in a reset cycle.
REQ-032 First accept possible on the first rising edge with rst = 0.

Verification
REQ-033 Reset then idle -> out_valid=0, in_ready=1, result=0x00, all flags 0.
REQ-034 W=8, op=ADD a=0x7F b=0x01, out_ready=1 -> next cycle result=0x80 zero=0 carry=0 ovf=1; a=0xFF b=0x01 -> result=0x00 zero=1 carry=1 ovf=0.
REQ-035 W=8, op=SUB a=0x05 b=0x05 -> result=0x00 zero=1 carry=1 ovf=0; a=0x00 b=0x01 -> result=0xFF carry=0 ovf=0; a=0x80 b=0x01 -> result=0x7F ovf=1.
REQ-036 Bitwise sweep a=0xCC b=0xAA ops 000..011,110,111 -> 0x88, 0xEE, 0x66, 0x11, 0xCC, 0x33; carry=ovf=0 on all.
REQ-037 Backpressure: out_ready=0, three back-to-back offers (ADD 1+1, ADD 2+2, ADD 3+3) -> first two accepted, in_ready=0 from cycle after second accept, head holds 0x02; raise out_ready -> outputs 0x02, 0x04, then third accepted and 0x06, in order.
REQ-038 Reset in FULL state -> next cycle out_valid=0, in_ready=1, all outputs 0; subsequent ADD 0x10+0x20 yields 0x30 one cycle after accept.
